// File: rtl/echo_indication_portal.sv
// Host-side indication portal: buffers ind_echo values in a small FIFO and
// serializes each one as a {header, payload} message on a first/deq method pair.
module echo_indication_portal #(
  parameter int          DEPTH     = 4,
  parameter int          AW        = 2,
  parameter logic [15:0] METHOD_ID = 16'h0001
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ind_echo__ENA,
  input  logic [31:0] ind_echo_v,
  output logic        ind_echo__RDY,
  output logic        msg_first__RDY,
  output logic [31:0] msg_first,
  output logic        msg_deq__RDY,
  input  logic        msg_deq__ENA,
  output logic [15:0] msg_count,
  output logic        proto_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a method fires when ENA is high at a CLK edge; ENA is only
  // legal while the matching RDY is high. RDY never depends on ENA in the
  // same cycle. An illegal ENA has no effect other than setting proto_err.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  localparam logic [31:0] HDR_WORD = {METHOD_ID, 16'd2};

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   msg_count_q, msg_count_d;
  logic          proto_err_q, proto_err_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    enq         = ind_echo__ENA && !full;
    deq         = msg_deq__ENA && (state_q == PAY);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    msg_count_d = msg_count_q;
    proto_err_d = proto_err_q;
    mem_d       = mem_q;

    if (enq) begin
      mem_d[wr_ptr_q] = ind_echo_v;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (deq) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      msg_count_d = msg_count_q + 16'd1;
    end
    if (enq && !deq) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!enq && deq) begin
      count_d = count_q - (AW+1)'(1);
    end

    if ((ind_echo__ENA && full) || (msg_deq__ENA && (state_q == IDLE))) begin
      proto_err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!empty) state_d = HDR;
      HDR:  if (msg_deq__ENA) state_d = PAY;
      // Looking at the post-update occupancy lets a value arriving during
      // the last payload start the next header without an idle cycle.
      PAY:  if (msg_deq__ENA) state_d = (count_d != '0) ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      msg_count_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      msg_count_q <= msg_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    msg_first = '0;
    unique case (state_q)
      HDR:     msg_first = HDR_WORD;
      PAY:     msg_first = mem_q[rd_ptr_q];
      default: msg_first = '0;
    endcase
  end

  assign ind_echo__RDY  = !full;
  assign msg_first__RDY = (state_q == HDR) || (state_q == PAY);
  assign msg_deq__RDY   = msg_first__RDY;
  assign msg_count      = msg_count_q;
  assign proto_err      = proto_err_q;
  assign dbg_state      = state_q;

endmodule
